// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if
// Groups the execute-side request, the divider-side control and the
// writeback-side result of the divide issue controller.
//   in_*   : request handshake from execute (valid/ready, operands, tag)
//   div_*  : magnitudes and load pulse to the divider, quotient/ready back
//   out_*  : one-cycle tagged result pulse to writeback with flags
//   busy   : pipeline stall while an operation is in flight
// Modports: slave is the controller itself; master is the surrounding
// logic that issues requests and hosts the divider.
interface div_issue_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [31:0]      in_dividend;
  logic [31:0]      in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      div_dividend;
  logic [31:0]      div_divisor;
  logic             div_ctrl;
  logic [31:0]      div_result;
  logic             div_ready;
  logic             out_valid;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_dbz;
  logic             out_timeout;
  logic             busy;

  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor, in_tag,
    input  div_result, div_ready,
    output in_ready, div_dividend, div_divisor, div_ctrl,
    output out_valid, out_result, out_tag, out_dbz, out_timeout, busy
  );

  modport master (
    output in_valid, in_signed, in_dividend, in_divisor, in_tag,
    output div_result, div_ready,
    input  in_ready, div_dividend, div_divisor, div_ctrl,
    input  out_valid, out_result, out_tag, out_dbz, out_timeout, busy
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
// Front/back-end controller around an iterative 32-bit unsigned divider.
// Accepts a request in IDLE, converts signed operands to magnitudes, pulses
// the divider load for one cycle, waits for the divider ready flag (with a
// timeout), then applies sign correction / divide-by-zero handling and
// returns a tagged one-cycle result.
// Ports:
//   clock   : system clock, all state on rising edge
//   reset_n : synchronous active-low reset
//   bus     : div_issue_ctrl_if.slave (request, divider and result signals)
module div_issue_ctrl #(
  parameter int TAG_W          = 5,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic           clock,
  input  logic           reset_n,
  div_issue_ctrl_if.slave bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int             CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]       state;
  logic [CNT_W-1:0] counter;
  logic [31:0]      mag_dividend;
  logic [31:0]      mag_divisor;
  logic [TAG_W-1:0] tag_q;
  logic             signed_q;
  logic             sign_dividend;
  logic             sign_divisor;
  logic             out_valid_q;
  logic [31:0]      out_result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_dbz_q;
  logic             out_timeout_q;
  logic             negate_result;

  // The quotient only needs negating when a signed op has operands of
  // opposite sign; 0x80000000 / -1 therefore passes through unchanged.
  assign negate_result = signed_q & (sign_dividend ^ sign_divisor);

  // Main FSM. Flags and out_valid default low every cycle so they only
  // ever appear together with the single DONE pulse. A zero divisor skips
  // the divider entirely and goes straight to DONE. In WAIT the first cycle
  // (counter==0) ignores div_ready since it may still be high from the
  // previous op; ready is tested before the timeout so it wins a tie.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      counter       <= '0;
      mag_dividend  <= '0;
      mag_divisor   <= '0;
      tag_q         <= '0;
      signed_q      <= 1'b0;
      sign_dividend <= 1'b0;
      sign_divisor  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_dbz_q     <= 1'b0;
      out_timeout_q <= 1'b0;
    end else begin
      out_valid_q   <= 1'b0;
      out_dbz_q     <= 1'b0;
      out_timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            tag_q         <= bus.in_tag;
            signed_q      <= bus.in_signed;
            sign_dividend <= bus.in_dividend[31];
            sign_divisor  <= bus.in_divisor[31];
            mag_dividend  <= (bus.in_signed && bus.in_dividend[31]) ?
                             -bus.in_dividend : bus.in_dividend;
            mag_divisor   <= (bus.in_signed && bus.in_divisor[31]) ?
                             -bus.in_divisor : bus.in_divisor;
            if (bus.in_divisor == 32'd0) begin
              state        <= ST_DONE;
              out_valid_q  <= 1'b1;
              out_dbz_q    <= 1'b1;
              out_result_q <= 32'hFFFF_FFFF;
              out_tag_q    <= bus.in_tag;
            end else begin
              state <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          counter <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if ((counter != '0) && bus.div_ready) begin
            state        <= ST_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= negate_result ? -bus.div_result : bus.div_result;
            out_tag_q    <= tag_q;
          end else if (counter == CNT_LIMIT) begin
            state         <= ST_DONE;
            out_valid_q   <= 1'b1;
            out_timeout_q <= 1'b1;
            out_result_q  <= '0;
            out_tag_q     <= tag_q;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready     = (state == ST_IDLE);
  assign bus.busy         = (state != ST_IDLE);
  assign bus.div_ctrl     = (state == ST_LAUNCH);
  assign bus.div_dividend = mag_dividend;
  assign bus.div_divisor  = mag_divisor;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_tag      = out_tag_q;
  assign bus.out_dbz      = out_dbz_q;
  assign bus.out_timeout  = out_timeout_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl
// Directed bench for div_issue_ctrl. The bench plays both the execute stage
// and the divider: it issues requests, and answers the load pulse by driving
// div_result/div_ready after a chosen delay. Expected values are hand-derived.
module tb_div_issue_ctrl;
  localparam int TAG_W = 5;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  int   ctrl_count;

  div_issue_ctrl_if #(.TAG_W(TAG_W)) bus();

  div_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(40)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts cycles in which the divider load pulse is high.
  initial ctrl_count = 0;
  always @(posedge clock) begin
    if (bus.div_ctrl === 1'b1) ctrl_count++;
  end

  // Last-resort guard so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents one request and holds it for exactly one accepting edge.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic [TAG_W-1:0] tag);
    bus.in_signed   = sgn;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    bus.in_tag      = tag;
    bus.in_valid    = 1'b1;
    step();
    bus.in_valid    = 1'b0;
  endtask

  // Waits (bounded) for out_valid; returns cycles waited.
  task automatic waitOut(output int cycles);
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 100) begin
      step();
      cycles++;
    end
    checkOutput("out_valid_seen", {31'b0, bus.out_valid}, 32'd1);
  endtask

  // One complete operation. delay<0 means the divider never answers;
  // otherwise div_result=q and div_ready=1 are driven delay cycles after
  // the LAUNCH cycle. lat is the expected edge count from accept to DONE.
  task automatic runOp(input string name, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tag,
                       input logic [31:0] mag_a, input logic [31:0] mag_b,
                       input int delay, input logic [31:0] q,
                       input logic [31:0] exp_res, input logic exp_dbz,
                       input logic exp_to, input int exp_pulses, input int lat,
                       input logic keep_ready);
    int start_count;
    int waited;
    start_count = ctrl_count;
    applyStimulus(sgn, a, b, tag);
    checkOutput({name, "_busy"}, {31'b0, bus.busy}, 32'd1);
    checkOutput({name, "_mag_dividend"}, bus.div_dividend, mag_a);
    checkOutput({name, "_mag_divisor"}, bus.div_divisor, mag_b);
    if (delay >= 0) begin
      repeat (delay) step();
      bus.div_result = q;
      bus.div_ready  = 1'b1;
    end
    waitOut(waited);
    if (delay >= 0) waited += delay;
    checkOutput({name, "_latency"}, waited, lat);
    checkOutput({name, "_result"}, bus.out_result, exp_res);
    checkOutput({name, "_tag"}, {27'b0, bus.out_tag}, {27'b0, tag});
    checkOutput({name, "_dbz"}, {31'b0, bus.out_dbz}, {31'b0, exp_dbz});
    checkOutput({name, "_timeout"}, {31'b0, bus.out_timeout}, {31'b0, exp_to});
    checkOutput({name, "_ctrl_pulses"}, ctrl_count - start_count, exp_pulses);
    if (!keep_ready) bus.div_ready = 1'b0;
    step();
    checkOutput({name, "_valid_drop"}, {31'b0, bus.out_valid}, 32'd0);
    checkOutput({name, "_flags_drop"}, {30'b0, bus.out_dbz, bus.out_timeout}, 32'd0);
    checkOutput({name, "_idle"}, {30'b0, bus.in_ready, bus.busy}, 32'd2);
  endtask

  initial begin
    int seen;
    checks          = 0;
    errors          = 0;
    reset_n         = 1'b0;
    bus.div_ready   = 1'b0;
    bus.div_result  = 32'd0;
    bus.in_valid    = 1'b1;
    bus.in_signed   = 1'b0;
    bus.in_dividend = 32'd100;
    bus.in_divisor  = 32'd7;
    bus.in_tag      = 5'd3;

    // Reset held two cycles with a request pending: nothing may be accepted.
    repeat (2) begin
      step();
      checkOutput("rst_busy", {31'b0, bus.busy}, 32'd0);
      checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("rst_div_ctrl", {31'b0, bus.div_ctrl}, 32'd0);
      checkOutput("rst_out_result", bus.out_result, 32'd0);
      checkOutput("rst_div_dividend", bus.div_dividend, 32'd0);
    end
    reset_n = 1'b1;

    // Unsigned 100/7, divider answers after 32 cycles.
    runOp("udiv", 1'b0, 32'd100, 32'd7, 5'd3, 32'd100, 32'd7,
          32, 32'd14, 32'd14, 1'b0, 1'b0, 1, 33, 1'b0);
    // Signed -100/7 -> -14.
    runOp("sdiv_neg", 1'b1, 32'hFFFF_FF9C, 32'd7, 5'd17, 32'd100, 32'd7,
          4, 32'd14, 32'hFFFF_FFF2, 1'b0, 1'b0, 1, 5, 1'b0);
    // Signed 100/-7 -> -14.
    runOp("sdiv_negb", 1'b1, 32'd100, 32'hFFFF_FFF9, 5'd5, 32'd100, 32'd7,
          3, 32'd14, 32'hFFFF_FFF2, 1'b0, 1'b0, 1, 4, 1'b0);
    // Signed -100/-7 -> 14; leave div_ready high to make it stale.
    runOp("sdiv_both", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd31, 32'd100, 32'd7,
          2, 32'd14, 32'd14, 1'b0, 1'b0, 1, 3, 1'b1);
    // Stale ready with old result 14 during the first WAIT cycle; the real
    // quotient 28 arrives in the second WAIT cycle and must be the one used.
    runOp("stale", 1'b0, 32'd200, 32'd7, 5'd8, 32'd200, 32'd7,
          2, 32'd28, 32'd28, 1'b0, 1'b0, 1, 3, 1'b0);
    // Unsigned op with bit31 set: no magnitude conversion, no negation.
    runOp("ubig", 1'b0, 32'hFFFF_FF9C, 32'd7, 5'd12, 32'hFFFF_FF9C, 32'd7,
          6, 32'h2492_4916, 32'h2492_4916, 1'b0, 1'b0, 1, 7, 1'b0);
    // Divide by zero: no load pulse, result on the cycle after accept.
    runOp("dbz", 1'b0, 32'd5, 32'd0, 5'd21, 32'd5, 32'd0,
          -1, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0, 1'b0);
    // Divider never answers: timeout when counter reaches 40.
    runOp("timeout", 1'b0, 32'd9, 32'd3, 5'd6, 32'd9, 32'd3,
          -1, 32'd0, 32'd0, 1'b0, 1'b1, 1, 42, 1'b0);

    // Reset during WAIT aborts with no result pulse.
    applyStimulus(1'b0, 32'd50, 32'd5, 5'd9);
    repeat (4) step();
    checkOutput("abort_in_wait", {31'b0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    step();
    checkOutput("abort_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("abort_div_divisor", bus.div_divisor, 32'd0);
    checkOutput("abort_div_ctrl", {31'b0, bus.div_ctrl}, 32'd0);
    reset_n = 1'b1;
    seen = 0;
    repeat (45) begin
      if (bus.out_valid === 1'b1) seen++;
      step();
    end
    checkOutput("abort_no_valid", seen, 0);

    // Signed overflow case: 0x80000000 / -1 -> 0x80000000, no flags.
    runOp("overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h8000_0000, 32'd1,
          5, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1, 6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
